// File: rtl/mux_2x1.sv
// PC-source selector for the IF stage: combinational 2:1 word mux feeding the PC
// register, plus a clocked debug side-block (registered copy and redirect counter).
module mux_2x1 #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] redirect_cnt,
  input  logic                 cnt_clr
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     w_out;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]     r_out_q;
  logic                 r_sel_q;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Select path: only an explicit 1 picks the redirect; the PC register samples this same cycle
  always_comb begin
    w_out = in_1;
    if (sel == 1'b1) begin
      w_out = in_2;
    end else begin
      w_out = in_1;
    end
  end

  // Redirect counter next value: clear wins over increment, saturates instead of wrapping
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (cnt_clr == 1'b1) begin
      w_cnt_nxt = {CNT_WIDTH{1'b0}};
    end else if ((sel == 1'b1) && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Debug registers: selected value, select and redirect count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_q <= {WIDTH{1'b0}};
      r_sel_q <= 1'b0;
      r_cnt   <= {CNT_WIDTH{1'b0}};
    end else begin
      r_out_q <= w_out;
      r_sel_q <= sel;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out          = w_out;
  assign out_q        = r_out_q;
  assign sel_q        = r_sel_q;
  assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_mux_2x1.sv
// Directed and table-driven bench for mux_2x1; a second instance with a 4-bit
// counter exercises saturation.
module tb_mux_2x1;

  logic        clk;
  logic        rstn;
  logic        sel;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_q;
  logic [15:0] redirect_cnt;
  logic        cnt_clr;

  logic        sel4;
  logic        clr4;
  logic [31:0] out4;
  logic [31:0] out_q4;
  logic        sel_q4;
  logic [3:0]  cnt4;

  int n_tests;
  int n_fail;

  mux_2x1 #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rstn(rstn), .sel(sel), .in_1(in_1), .in_2(in_2),
    .out(out), .out_q(out_q), .sel_q(sel_q),
    .redirect_cnt(redirect_cnt), .cnt_clr(cnt_clr)
  );

  mux_2x1 #(.WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .sel(sel4), .in_1(in_1), .in_2(in_2),
    .out(out4), .out_q(out_q4), .sel_q(sel_q4),
    .redirect_cnt(cnt4), .cnt_clr(clr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] prev_out;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0000_0100, 32'h0000_0004};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_0100, 32'h0000_0100};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h1234_5678, 32'h8000_0001, 32'h8000_0001};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    vecs[6] = '{1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[7] = '{1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};

    rstn = 1'b0; sel = 1'b0; cnt_clr = 1'b0; sel4 = 1'b0; clr4 = 1'b0;
    in_1 = 32'h0000_0004; in_2 = 32'h0000_0100;
    #2;
    check("rst_out_q", out_q, 32'h0);
    check("rst_sel_q", {31'h0, sel_q}, 32'h0);
    check("rst_cnt", {16'h0, redirect_cnt}, 32'h0);
    check("rst_out_comb", out, 32'h0000_0004);
    tick(); tick();
    #2 rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; in_1 = vecs[i].in_1; in_2 = vecs[i].in_2;
      #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom(); rb = $urandom(); rs = 1'($urandom_range(1, 0));
      sel = rs; in_1 = ra; in_2 = rb;
      #1;
      if (i % 100 == 0 || out !== (rs ? rb : ra))
        check("rand_out", out, rs ? rb : ra);
    end

    // Registered path
    tick();
    sel = 1'b1; in_2 = 32'hDEAD_BEEF; in_1 = 32'h0000_0010;
    tick();
    check("reg_out_q_N", out_q, 32'hDEAD_BEEF);
    check("reg_sel_q_N", {31'h0, sel_q}, 32'h1);
    sel = 1'b0; in_1 = 32'h0000_0008;
    tick();
    check("reg_out_q_N1", out_q, 32'h0000_0008);
    check("reg_sel_q_N1", {31'h0, sel_q}, 32'h0);

    // Counter: 7 redirects then 3 idle cycles
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("cnt_cleared", {16'h0, redirect_cnt}, 32'h0);
    sel = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("cnt_7", {16'h0, redirect_cnt}, 32'd7);
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cnt_hold_7", {16'h0, redirect_cnt}, 32'd7);
    end

    // Clear priority over a simultaneous redirect
    sel = 1'b1; cnt_clr = 1'b1;
    tick();
    check("clr_prio", {16'h0, redirect_cnt}, 32'h0);
    cnt_clr = 1'b0;
    tick();
    check("cnt_after_clr", {16'h0, redirect_cnt}, 32'd1);

    // Asynchronous reset mid-count
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    sel = 1'b1; in_2 = 32'h0BAD_CAFE; in_1 = 32'h0000_0044;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_cnt", {16'h0, redirect_cnt}, 32'd5);
    check("pre_rst_out_q", out_q, 32'h0BAD_CAFE);
    rstn = 1'b0;
    #1;
    check("async_rst_out_q", out_q, 32'h0);
    check("async_rst_sel_q", {31'h0, sel_q}, 32'h0);
    check("async_rst_cnt", {16'h0, redirect_cnt}, 32'h0);
    check("rst_out_sel1", out, 32'h0BAD_CAFE);
    sel = 1'b0;
    #1;
    check("rst_out_sel0", out, 32'h0000_0044);
    sel = 1'b1;
    tick();
    check("rst_hold_cnt", {16'h0, redirect_cnt}, 32'h0);
    check("rst_hold_out_q", out_q, 32'h0);
    #2 rstn = 1'b1;
    #1;
    check("post_rel_cnt", {16'h0, redirect_cnt}, 32'h0);
    tick();
    check("post_rel_cnt1", {16'h0, redirect_cnt}, 32'd1);
    check("post_rel_out_q", out_q, 32'h0BAD_CAFE);

    // Saturation of the 4-bit counter
    check("sat_start", {28'h0, cnt4}, 32'h0);
    sel4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), {28'h0, cnt4}, (i > 15) ? 32'd15 : 32'(i));
    end
    sel4 = 1'b0;
    tick();
    check("sat_hold", {28'h0, cnt4}, 32'd15);

    // Full-width pass-through with sel toggling every cycle
    in_1 = 32'hFFFF_FFFF; in_2 = 32'h0000_0000; sel = 1'b0;
    #1;
    prev_out = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fw_out_q", out_q, prev_out);
      sel = ~sel;
      #1;
      prev_out = sel ? 32'h0000_0000 : 32'hFFFF_FFFF;
      check("fw_out", out, prev_out);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
